alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_comb.sv | 89 ++++++++
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the opcode values, the FSM state encoding and helpers that say
// which opcodes are legal and which ones need the iterative MUL/DIV path.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_ADDC = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OP_W-1:0] OP_SUBC = 4'd3;
    localparam logic [OP_W-1:0] OP_AND  = 4'd4;
    localparam logic [OP_W-1:0] OP_OR   = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd7;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd9;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd10;
    localparam logic [OP_W-1:0] OP_CMP  = 4'd11;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd12;
    localparam logic [OP_W-1:0] OP_DIV  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // MUL and DIV are the only opcodes that iterate.
    function automatic logic is_multi(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Opcodes above DIV are reserved.
    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return op <= OP_DIV;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU (ADD..CMP).
// Ports:
//   op_i   opcode
//   a_i    operand A
//   b_i    operand B / shift amount (low clog2(WIDTH) bits)
//   cf_i   carry/borrow in for ADDC/SUBC
//   res_c  result
//   cf_c   carry / borrow / last bit shifted out
//   zf_c   zero flag (for CMP: the A-B difference is zero)
// Any opcode outside ADD..CMP yields res=0, cf=1.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cf_i,
    output logic [WIDTH-1:0] res_c,
    output logic             cf_c,
    output logic             zf_c
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned SW = $clog2(WIDTH);

    logic [SW-1:0] sh;
    logic          add_cin;
    logic          sub_cin;
    logic [W1-1:0] sum;
    logic [W1-1:0] diff;
    logic [W1-1:0] sll_w;
    logic [W1-1:0] srl_w;
    logic [W1-1:0] sra_w;

    // Shifters carry one guard bit so the last bit shifted out falls into it.
    always_comb begin
        sh      = b_i[SW-1:0];
        add_cin = (op_i == OP_ADDC) & cf_i;
        sub_cin = (op_i == OP_SUBC) & cf_i;
        sum     = {1'b0, a_i} + {1'b0, b_i} + W1'(add_cin);
        diff    = {1'b0, a_i} - {1'b0, b_i} - W1'(sub_cin);
        sll_w   = {1'b0, a_i} << sh;
        srl_w   = {a_i, 1'b0} >> sh;
        sra_w   = $signed({a_i, 1'b0}) >>> sh;

        res_c = '0;
        cf_c  = 1'b0;
        case (op_i)
            OP_ADD, OP_ADDC: begin
                res_c = sum[WIDTH-1:0];
                cf_c  = sum[WIDTH];
            end
            OP_SUB, OP_SUBC: begin
                res_c = diff[WIDTH-1:0];
                cf_c  = diff[WIDTH];
            end
            OP_AND: res_c = a_i & b_i;
            OP_OR:  res_c = a_i | b_i;
            OP_XOR: res_c = a_i ^ b_i;
            OP_NOT: res_c = ~a_i;
            OP_SLL: begin
                res_c = sll_w[WIDTH-1:0];
                cf_c  = sll_w[WIDTH];
            end
            OP_SRL: begin
                res_c = srl_w[WIDTH:1];
                cf_c  = srl_w[0];
            end
            OP_SRA: begin
                res_c = sra_w[WIDTH:1];
                cf_c  = sra_w[0];
            end
            OP_CMP: begin
                res_c = a_i;
                cf_c  = diff[WIDTH];
            end
            default: begin
                res_c = '0;
                cf_c  = 1'b1;
            end
        endcase

        // CMP keeps A on the result bus, so its zero flag tracks the difference.
        zf_c = (op_i == OP_CMP) ? (diff[WIDTH-1:0] == '0) : (res_c == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops through alu_comb, MUL (shift-add) and
// DIV (restoring) iterate one bit per cycle over WIDTH cycles.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start          request, accepted only in IDLE
//   op             opcode, sampled with start
//   reg_A, reg_B   operands, sampled with start
//   cf_in          carry/borrow in for ADDC/SUBC
//   busy           high from the cycle after accept until done
//   done           one-cycle pulse when results update
//   ALUo           result, held until next done
//   cf_out, zf_out carry and zero flags, held until next done
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MULDIV_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] reg_A,
    input  logic [WIDTH-1:0] reg_B,
    input  logic             cf_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUo,
    output logic             cf_out,
    output logic             zf_out
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    p_q, p_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mul_q, mul_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic             cf_q, cf_d;
    logic             zf_q, zf_d;

    logic [WIDTH-1:0] comb_res;
    logic             comb_cf;
    logic             comb_zf;

    logic [W1-1:0]    mul_sum;
    logic [W1-1:0]    rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [W2-1:0]    step;
    logic             md_illegal;
    logic             div_by_zero;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .op_i  (op),
        .a_i   (reg_A),
        .b_i   (reg_B),
        .cf_i  (cf_in),
        .res_c (comb_res),
        .cf_c  (comb_cf),
        .zf_c  (comb_zf)
    );

    // One iteration of either MUL or DIV on the shared {hi, lo} register.
    // MUL: lo holds the multiplier, hi accumulates; the pair shifts right.
    // DIV: hi is the partial remainder, lo shifts the dividend out and the
    //      quotient bits in from the bottom.
    always_comb begin
        mul_sum = {1'b0, p_q[W2-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : W1'(0));
        rem_sh  = p_q[W2-1:WIDTH-1];
        div_ge  = rem_sh >= {1'b0, b_q};
        div_rem = div_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        step    = mul_q ? {mul_sum, p_q[WIDTH-1:1]}
                        : {div_rem, p_q[WIDTH-2:0], div_ge};
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        b_d         = b_q;
        mul_d       = mul_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        alu_d       = alu_q;
        cf_d        = cf_q;
        zf_d        = zf_q;
        md_illegal  = is_multi(op) && (MULDIV_EN == 0);
        div_by_zero = (op == OP_DIV) && (reg_B == '0);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (is_multi(op) && !md_illegal && !div_by_zero) begin
                        state_d = ST_ITER;
                        cnt_d   = '0;
                        p_d     = {WIDTH'(0), reg_A};
                        b_d     = reg_B;
                        mul_d   = (op == OP_MUL);
                    end else begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        if (md_illegal || !is_legal(op)) begin
                            alu_d = '0;
                            cf_d  = 1'b1;
                            zf_d  = 1'b1;
                        end else if (div_by_zero) begin
                            alu_d = '1;
                            cf_d  = 1'b1;
                            zf_d  = 1'b0;
                        end else begin
                            alu_d = comb_res;
                            cf_d  = comb_cf;
                            zf_d  = comb_zf;
                        end
                    end
                end
            end
            ST_ITER: begin
                busy_d = 1'b1;
                p_d    = step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    alu_d   = step[WIDTH-1:0];
                    cf_d    = mul_q && (step[W2-1:WIDTH] != '0);
                    zf_d    = (step[WIDTH-1:0] == '0);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            b_q     <= '0;
            mul_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            alu_q   <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            b_q     <= b_d;
            mul_q   <= mul_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            alu_q   <= alu_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ALUo   = alu_q;
    assign cf_out = cf_q;
    assign zf_out = zf_q;

endmodule
